// File: rtl/mhp_rx_parser.sv
// Receive-side MHP frame parser: filters on destination MAC and ethertype, captures the
// 8-byte MHP header and streams packet_size_in_bytes payload bytes with padding/FCS removed.
module mhp_rx_parser #(
    parameter logic [47:0] BOARD_MAC     = 48'h26731bc9110c,
    parameter logic [15:0] ETHERTYPE_MHP = 16'h88b5,
    parameter bit          ACCEPT_BCAST  = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    input  logic        in_last,
    output logic        out_valid,
    output logic [7:0]  out_data,
    output logic        out_last,
    output logic        hdr_valid,
    output logic [63:0] mhp_hdr,
    output logic        frame_done,
    output logic        frame_err,
    output logic [2:0]  err_code
);
    // state | meaning
    // IDLE  | waiting for preamble byte 0 of the next frame
    // PRE   | checking preamble bytes 1..7 (0x55 x6 then 0xD5)
    // ETH   | destination MAC (bytes 0-5) and ethertype (bytes 12-13)
    // MHP   | shifting in the 8-byte MHP header
    // PAY   | payload through the 4-byte FCS delay line
    // DROP  | discarding a rejected frame until in_last
    typedef enum logic [2:0] {IDLE, PRE, ETH, MHP, PAY, DROP} state_t;

    localparam logic [2:0] E_OK    = 3'd0;
    localparam logic [2:0] E_PRE   = 3'd1;
    localparam logic [2:0] E_MAC   = 3'd2;
    localparam logic [2:0] E_ETYPE = 3'd3;
    localparam logic [2:0] E_RUNT  = 3'd4;
    localparam logic [2:0] E_LEN   = 3'd5;

    state_t          state, state_nx;
    logic [10:0]     cnt, cnt_nx;
    logic [10:0]     emit_cnt, emit_cnt_nx;
    logic [10:0]     pkt_size, pkt_size_nx;
    logic [3:0][7:0] dly, dly_nx;
    logic [55:0]     hdr_sh, hdr_sh_nx;
    logic            mac_uc, mac_uc_nx, mac_bc, mac_bc_nx, et_hi, et_hi_nx;
    logic [2:0]      drop_code, drop_code_nx;

    logic            out_valid_nx, out_last_nx, hdr_valid_nx;
    logic [7:0]      out_data_nx;
    logic [63:0]     mhp_hdr_nx;
    logic            frame_done_nx, frame_err_nx;
    logic [2:0]      err_code_nx;

    logic            fail, done, emit_now;
    logic [2:0]      fail_code, done_code, pay_code;
    logic [10:0]     cnt_inc, emit_after;
    logic [47:0]     mac_sel;
    logic [63:0]     hdr_full;

    always_comb begin
        state_nx      = state;
        cnt_nx        = cnt;
        emit_cnt_nx   = emit_cnt;
        pkt_size_nx   = pkt_size;
        dly_nx        = dly;
        hdr_sh_nx     = hdr_sh;
        mac_uc_nx     = mac_uc;
        mac_bc_nx     = mac_bc;
        et_hi_nx      = et_hi;
        drop_code_nx  = drop_code;
        out_valid_nx  = 1'b0;
        out_data_nx   = out_data;
        out_last_nx   = 1'b0;
        hdr_valid_nx  = 1'b0;
        mhp_hdr_nx    = mhp_hdr;
        frame_done_nx = 1'b0;
        frame_err_nx  = 1'b0;
        err_code_nx   = E_OK;
        fail          = 1'b0;
        fail_code     = E_OK;
        done          = 1'b0;
        done_code     = E_OK;
        pay_code      = E_OK;
        cnt_inc       = (cnt == 11'h7ff) ? cnt : cnt + 11'd1;
        mac_sel       = BOARD_MAC << {cnt[2:0], 3'b000};
        hdr_full      = {hdr_sh, in_data};
        // a byte pops out of the delay line only once it already holds four bytes
        emit_now      = (cnt >= 11'd4) && (emit_cnt < pkt_size);
        emit_after    = emit_cnt + {10'd0, emit_now};

        if (in_valid) begin
            case (state)
                IDLE: begin
                    state_nx = PRE;
                    cnt_nx   = 11'd1;
                    if (in_data != 8'h55) begin
                        fail      = 1'b1;
                        fail_code = E_PRE;
                    end
                end
                PRE: begin
                    if (in_data != ((cnt == 11'd7) ? 8'hd5 : 8'h55)) begin
                        fail      = 1'b1;
                        fail_code = E_PRE;
                    end else if (cnt == 11'd7) begin
                        state_nx = ETH;
                        cnt_nx   = 11'd0;
                    end else begin
                        cnt_nx = cnt_inc;
                    end
                end
                ETH: begin
                    cnt_nx = cnt_inc;
                    if (cnt < 11'd6) begin
                        mac_uc_nx = ((cnt == 11'd0) || mac_uc) && (in_data == mac_sel[47:40]);
                        mac_bc_nx = ((cnt == 11'd0) || mac_bc) && (in_data == 8'hff);
                        if ((cnt == 11'd5) && !(mac_uc_nx || (ACCEPT_BCAST && mac_bc_nx))) begin
                            fail      = 1'b1;
                            fail_code = E_MAC;
                        end
                    end
                    if (cnt == 11'd12)
                        et_hi_nx = (in_data == ETHERTYPE_MHP[15:8]);
                    if (cnt == 11'd13) begin
                        if (!(et_hi && (in_data == ETHERTYPE_MHP[7:0]))) begin
                            fail      = 1'b1;
                            fail_code = E_ETYPE;
                        end else begin
                            state_nx = MHP;
                            cnt_nx   = 11'd0;
                        end
                    end
                end
                MHP: begin
                    hdr_sh_nx = hdr_full[55:0];
                    cnt_nx    = cnt_inc;
                    if ((cnt == 11'd7) && !in_last) begin
                        mhp_hdr_nx   = hdr_full;
                        hdr_valid_nx = 1'b1;
                        pkt_size_nx  = hdr_full[15:5];
                        state_nx     = PAY;
                        cnt_nx       = 11'd0;
                        emit_cnt_nx  = 11'd0;
                    end
                end
                PAY: begin
                    dly_nx = {dly[2:0], in_data};
                    cnt_nx = cnt_inc;
                    if (emit_now) begin
                        out_valid_nx = 1'b1;
                        out_data_nx  = dly[3];
                        out_last_nx  = (emit_after == pkt_size) || in_last;
                        emit_cnt_nx  = emit_after;
                    end
                    if (cnt < 11'd3)
                        pay_code = E_RUNT;
                    else if (emit_after < pkt_size)
                        pay_code = E_LEN;
                end
                default: ;
            endcase

            if (in_last) begin
                done = 1'b1;
                if (state == DROP)
                    done_code = drop_code;
                else if (fail)
                    done_code = fail_code;
                else if (state == PAY)
                    done_code = pay_code;
                else
                    done_code = E_RUNT;
            end

            if (done) begin
                frame_done_nx = 1'b1;
                frame_err_nx  = (done_code != E_OK);
                err_code_nx   = done_code;
                state_nx      = IDLE;
                cnt_nx        = 11'd0;
                emit_cnt_nx   = 11'd0;
            end else if (fail) begin
                state_nx     = DROP;
                drop_code_nx = fail_code;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            emit_cnt   <= '0;
            pkt_size   <= '0;
            dly        <= '0;
            hdr_sh     <= '0;
            mac_uc     <= 1'b0;
            mac_bc     <= 1'b0;
            et_hi      <= 1'b0;
            drop_code  <= E_OK;
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_last   <= 1'b0;
            hdr_valid  <= 1'b0;
            mhp_hdr    <= '0;
            frame_done <= 1'b0;
            frame_err  <= 1'b0;
            err_code   <= E_OK;
        end else begin
            state      <= state_nx;
            cnt        <= cnt_nx;
            emit_cnt   <= emit_cnt_nx;
            pkt_size   <= pkt_size_nx;
            dly        <= dly_nx;
            hdr_sh     <= hdr_sh_nx;
            mac_uc     <= mac_uc_nx;
            mac_bc     <= mac_bc_nx;
            et_hi      <= et_hi_nx;
            drop_code  <= drop_code_nx;
            out_valid  <= out_valid_nx;
            out_data   <= out_data_nx;
            out_last   <= out_last_nx;
            hdr_valid  <= hdr_valid_nx;
            mhp_hdr    <= mhp_hdr_nx;
            frame_done <= frame_done_nx;
            frame_err  <= frame_err_nx;
            err_code   <= err_code_nx;
        end
    end
endmodule

// File: doc/mhp_rx_parser.md
# mhp_rx_parser

Receive-side frame parser that sits directly downstream of the Ethernet byte-stream input and upstream of the per-task processing stages. It consumes one frame per burst (preamble, Ethernet header, MHP header, payload, FCS), filters on destination MAC and the MHP ethertype, and captures the 8-byte MHP header. It streams exactly `packet_size_in_bytes` payload bytes downstream, with padding and FCS stripped, and reports a per-frame status. It does not check FCS; a separate stage does that.

## Interface
- `BOARD_MAC`, 48'h26731bc9110c, accepted unicast destination address.
- `ETHERTYPE_MHP`, 16'h88b5, required ethertype.
- `ACCEPT_BCAST`, 1, when 1, also accept destination ff:ff:ff:ff:ff:ff.
- `clk` in 1, single clock.
- `rst_n` in 1, asynchronous active-low reset.
- `in_valid` in 1, input byte qualifier. Gaps (bubbles) are allowed mid-frame.
- `in_data` in 8, frame byte; the first byte is preamble byte 0.
- `in_last` in 1, marks the final FCS byte of the frame.
- `out_valid` out 1, payload byte qualifier.
- `out_data` out 8, payload byte.
- `out_last` out 1, marks the last payload byte.
- `hdr_valid` out 1, one-cycle pulse when `mhp_hdr` has been updated.
- `mhp_hdr` out 64, captured MHP header. The first header byte maps to [63:56]. Bit map: [63] cyclic_prefix, [62] compression, [61] scrambling, [60:59] line_code, [58:56] modulation, [55:40] seed, [39:32] segments_number, [31:24] segment_index, [23:16] task_number, [15:5] packet_size_in_bytes, [4:1] reserved, [0] ping_pong.
- `frame_done` out 1, one-cycle status pulse per input frame.
- `frame_err` out 1, valid with `frame_done`; 1 means the frame was rejected or malformed.
- `err_code` out 3, valid with `frame_done`. Codes: 0 ok, 1 preamble, 2 dst MAC, 3 ethertype, 4 runt, 5 length.

## Operation
- FSM states: IDLE, PRE, ETH, MHP, PAY, DROP. All input-driven transitions advance only on `in_valid`.
- IDLE → PRE on the first valid byte, which is counted as preamble byte 0.
- PRE checks 7×0x55 followed by 0xD5.
  - Mismatch → DROP with code 1.
- ETH checks 14 bytes. Bytes 0–5 are the destination MAC, MSB first; bytes 12–13 are the ethertype.
  - MAC mismatch → DROP with code 2, decided at byte 5.
  - Ethertype mismatch → DROP with code 3, decided at byte 13.
- MHP shifts 8 bytes into `mhp_hdr`. After the 8th byte: `hdr_valid` pulses and the state moves to PAY.
- PAY pushes every byte into a 4-deep delay line.
  - Once the delay line is full, each new byte pops the oldest entry. This withholds the 4 FCS bytes.
  - A popped byte is emitted only while emitted count < `packet_size_in_bytes`.
  - The byte that makes emitted count equal to size carries `out_last`.
  - Popped bytes beyond size are padding and are discarded silently.
- Error in any state makes the FSM go to DROP. The first error detected wins. DROP discards bytes until `in_last`.
- `in_last` in PRE, ETH, MHP, or in PAY with fewer than 4 bytes received → code 4.
- `in_last` in PAY with emitted count < size → code 5, and the final popped byte is emitted with `out_last=1`.
  - Exception: size==0 emits nothing and is code 0 when at least 4 PAY bytes were received.
- `frame_done` is raised for every frame, accepted or not. The FSM returns to IDLE.
- `mhp_hdr` holds its value until the next frame completes its MHP stage.

## Timing
- Reset (asynchronous, any time including mid-frame): FSM to IDLE, delay line and counters cleared. All outputs 0, including `mhp_hdr`. The partial frame produces no `frame_done`.
- All outputs are registered.
- `out_*` rise 1 cycle after the `in_valid` cycle that pops the byte.
- `hdr_valid` rises 1 cycle after MHP byte 7 is accepted.
- `frame_done` rises 1 cycle after `in_last` is accepted.
- A new frame may start on the cycle immediately after `in_last`. Its first byte is handled in IDLE while `frame_done` of the previous frame is high.
- Counters: the byte counter is 11 bits and saturates, so it cannot wrap. Emitted count is compared against the 11-bit size.
- No backpressure. The downstream stage must accept one byte per cycle.

## Test plan
- Good frame to BOARD_MAC, ethertype 88b5, size=100, 100 payload bytes 0x00..0x63 + FCS → 100 output bytes in order, `out_last` on 0x63, `hdr_valid` once, `mhp_hdr` equal to the driven header, `frame_done` with err=0 and code 0.
- Size=10, payload padded to 38 bytes → exactly 10 bytes out, `out_last` on the 10th byte, code 0.
- Destination 26:73:1b:c9:11:0d → no output, no `hdr_valid`, code 2. Broadcast destination with ACCEPT_BCAST=1 → accepted. Ethertype 0x0800 → code 3.
- Preamble byte 3 = 0x54 → code 1. `in_last` at MHP byte 5 → code 4. Back-to-back frame follows the very next cycle → second frame parsed correctly.
- Size=200 but only 150 payload bytes → 150 bytes out, last one with `out_last`, code 5.
- Random `in_valid` bubbles over a good frame → identical output sequence. `rst_n` low mid-payload → all outputs 0 immediately; the next good frame parses correctly.
